// File: rtl/isa_pkg.sv
// ISA constants shared by the instruction-issue encoder: opcodes, ALU codes,
// instruction field positions and the packed control bundle.
package isa_pkg;

  localparam int INSTR_W = 32;

  localparam logic [3:0] OP_NOP      = 4'h0;
  localparam logic [3:0] OP_STORE    = 4'h3;
  localparam logic [3:0] OP_ADD      = 4'h4;
  localparam logic [3:0] OP_ADDI     = 4'h5;
  localparam logic [3:0] OP_NEG      = 4'h6;
  localparam logic [3:0] OP_SUB      = 4'h7;
  localparam logic [3:0] OP_JUMP     = 4'h8;
  localparam logic [3:0] OP_BRZ      = 4'h9;
  localparam logic [3:0] OP_WHEREAMI = 4'hA;
  localparam logic [3:0] OP_BRN      = 4'hB;
  localparam logic [3:0] OP_LOAD     = 4'hE;
  localparam logic [3:0] OP_SAVEPC   = 4'hF;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_NEG  = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b100;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;
  localparam int RD_MSB = 27;
  localparam int RD_LSB = 22;
  localparam int RS_MSB = 21;
  localparam int RS_LSB = 16;
  localparam int RT_MSB = 15;
  localparam int RT_LSB = 10;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       memwrite;
    logic       memread;
    logic       alu_src;
    logic       regwrt;
    logic       brz;
    logic       brn;
    logic       jump;
    logic       memtoreg;
    logic       pctoreg;
  } ctl_t;

  // Flag order after alu_op: memwrite memread alu_src regwrt brz brn jump memtoreg pctoreg
  localparam ctl_t CTL_NOP      = {ALU_NONE, 9'b000000000};
  localparam ctl_t CTL_SAVEPC   = {ALU_ADD,  9'b001100001};
  localparam ctl_t CTL_LOAD     = {ALU_PASS, 9'b010100010};
  localparam ctl_t CTL_STORE    = {ALU_PASS, 9'b100000000};
  localparam ctl_t CTL_ADD      = {ALU_ADD,  9'b000100000};
  localparam ctl_t CTL_ADDI     = {ALU_ADD,  9'b001100000};
  localparam ctl_t CTL_NEG      = {ALU_NEG,  9'b000100000};
  localparam ctl_t CTL_SUB      = {ALU_SUB,  9'b000100000};
  localparam ctl_t CTL_JUMP     = {ALU_PASS, 9'b000000100};
  localparam ctl_t CTL_BRZ      = {ALU_PASS, 9'b000010000};
  localparam ctl_t CTL_WHEREAMI = {ALU_PASS, 9'b000100001};
  localparam ctl_t CTL_BRN      = {ALU_PASS, 9'b000001000};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  function automatic logic [INSTR_W-1:0] pack_instr(input logic [3:0] op,
                                                    input logic [5:0] rd,
                                                    input logic [5:0] rs,
                                                    input logic [5:0] rt);
    logic [INSTR_W-1:0] w;
    w                 = '0;
    w[OP_MSB:OP_LSB]  = op;
    w[RD_MSB:RD_LSB]  = rd;
    w[RS_MSB:RS_LSB]  = rs;
    w[RT_MSB:RT_LSB]  = rt;
    return w;
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational control-bundle to opcode encoder; any bundle that is not an
// exact match of a known opcode's control pattern is flagged illegal.
module instr_encode
  import isa_pkg::*;
(
  input  ctl_t       ctl,
  output logic [3:0] opcode,
  output logic       legal
);

  always_comb begin
    opcode = OP_NOP;
    legal  = 1'b1;
    case (ctl)
      CTL_NOP:      opcode = OP_NOP;
      CTL_SAVEPC:   opcode = OP_SAVEPC;
      CTL_LOAD:     opcode = OP_LOAD;
      CTL_STORE:    opcode = OP_STORE;
      CTL_ADD:      opcode = OP_ADD;
      CTL_ADDI:     opcode = OP_ADDI;
      CTL_NEG:      opcode = OP_NEG;
      CTL_SUB:      opcode = OP_SUB;
      CTL_JUMP:     opcode = OP_JUMP;
      CTL_BRZ:      opcode = OP_BRZ;
      CTL_WHEREAMI: opcode = OP_WHEREAMI;
      CTL_BRN:      opcode = OP_BRN;
      default:      legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_issue_encoder.sv
// Encodes control bundles back into instruction words and streams them into
// instruction memory starting at BASE, one word per cycle, for up to DEPTH words.
module instr_issue_encoder
  import isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic               memwrite,
  input  logic               memread,
  input  logic               alu_src,
  input  logic               regwrt,
  input  logic               brz,
  input  logic               brn,
  input  logic               jump,
  input  logic               memtoreg,
  input  logic               pctoreg,
  input  logic [5:0]         rd,
  input  logic [5:0]         rs,
  input  logic [5:0]         rt,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               err_pulse,
  output logic               err_sticky,
  output logic [ADDR_W-1:0]  err_addr,
  output logic [ADDR_W:0]    count,
  output logic               full
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W:0]   LAST_CNT  = (ADDR_W+1)'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              legal;
  logic              last_word;
  logic [3:0]        opcode;
  ctl_t              ctl;

  assign ctl = '{alu_op:   alu_op,
                 memwrite: memwrite,
                 memread:  memread,
                 alu_src:  alu_src,
                 regwrt:   regwrt,
                 brz:      brz,
                 brn:      brn,
                 jump:     jump,
                 memtoreg: memtoreg,
                 pctoreg:  pctoreg};

  instr_encode u_encode (
    .ctl    (ctl),
    .opcode (opcode),
    .legal  (legal)
  );

  assign in_ready  = (state == ST_RUN) && !start;
  assign accept    = in_valid && in_ready;
  assign full      = (state == ST_FULL);
  // count already includes every earlier legal accept, so this flags the DEPTH-th one
  assign last_word = (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: state_nxt = ST_IDLE;
      ST_RUN:  if (accept && legal && last_word) state_nxt = ST_FULL;
      ST_FULL: state_nxt = ST_FULL;
      default: state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_RUN;
  end

  // Output stage: a write accepted this cycle lands next cycle even if start arrives then.
  always_ff @(posedge clk) begin
    if (rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      err_pulse  <= 1'b0;
    end else begin
      imem_we   <= accept && legal;
      err_pulse <= accept && !legal;
      imem_addr <= ptr;
      if (accept && legal) imem_wdata <= pack_instr(opcode, rd, rs, rt);
    end
  end

  // The pointer stops on the last slot so it never runs past BASE+DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= BASE_ADDR;
      count      <= '0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (start) begin
      ptr        <= BASE_ADDR;
      count      <= '0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
    end else if (accept) begin
      if (legal) begin
        count <= count + (ADDR_W+1)'(1);
        if (!last_word) ptr <= ptr + ADDR_W'(1);
      end else begin
        err_sticky <= 1'b1;
        err_addr   <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_instr_issue_encoder.sv
// Bench for instr_issue_encoder: spec opcode table, directed load sequences and
// a randomized phase scored against a cycle-level behavioural model.
module tb_instr_issue_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
  localparam int BASE   = 0;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [11:0] ctl_in;
  logic [5:0]  rd_in, rs_in, rt_in;

  logic              in_ready, imem_we, err_pulse, err_sticky, full;
  logic [ADDR_W-1:0] imem_addr, err_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;

  logic              in_ready4, imem_we4, err_pulse4, err_sticky4, full4;
  logic [ADDR_W-1:0] imem_addr4, err_addr4;
  logic [31:0]       imem_wdata4;
  logic [ADDR_W:0]   count4;

  always #5 clk = ~clk;

  instr_issue_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(ctl_in[11:9]), .memwrite(ctl_in[8]), .memread(ctl_in[7]), .alu_src(ctl_in[6]),
    .regwrt(ctl_in[5]), .brz(ctl_in[4]), .brn(ctl_in[3]), .jump(ctl_in[2]),
    .memtoreg(ctl_in[1]), .pctoreg(ctl_in[0]), .rd(rd_in), .rs(rs_in), .rt(rt_in),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_addr(err_addr),
    .count(count), .full(full));

  instr_issue_encoder #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE(0)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready4),
    .alu_op(ctl_in[11:9]), .memwrite(ctl_in[8]), .memread(ctl_in[7]), .alu_src(ctl_in[6]),
    .regwrt(ctl_in[5]), .brz(ctl_in[4]), .brn(ctl_in[3]), .jump(ctl_in[2]),
    .memtoreg(ctl_in[1]), .pctoreg(ctl_in[0]), .rd(rd_in), .rs(rs_in), .rt(rt_in),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .err_pulse(err_pulse4), .err_sticky(err_sticky4), .err_addr(err_addr4),
    .count(count4), .full(full4));

  // ctl layout: alu_op[2:0] memwrite memread alu_src regwrt brz brn jump memtoreg pctoreg
  typedef struct {
    logic [11:0] ctl;
    logic [3:0]  op;
    bit          legal;
  } vec_t;

  vec_t vt[15];

  int nerr = 0;
  int nchk = 0;

  bit m_run, m_full, m_sticky;
  int m_ptr, m_count, m_eaddr;

  int w4_n = 0;
  int w4_last = -1;

  always @(negedge clk) begin
    if (imem_we4) begin
      w4_n++;
      w4_last = int'(imem_addr4);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; model predicts what the edge produces, then outputs are compared.
  task automatic step();
    bit         acc, lg, e_we, e_ep;
    logic [3:0] op;
    int         ea;
    lg = 1'b0;
    op = 4'h0;
    for (int i = 0; i < 12; i++) begin
      if (vt[i].ctl == ctl_in) begin
        lg = 1'b1;
        op = vt[i].op;
      end
    end
    acc  = in_valid && m_run && !m_full && !start && !rst;
    e_we = acc && lg;
    e_ep = acc && !lg;
    ea   = m_ptr;
    if (rst || start) begin
      m_run    = !rst;
      m_full   = 1'b0;
      m_ptr    = BASE;
      m_count  = 0;
      m_sticky = 1'b0;
      m_eaddr  = 0;
    end else if (acc) begin
      if (lg) begin
        m_count++;
        if (m_count == DEPTH) m_full = 1'b1;
        else m_ptr++;
      end else begin
        m_sticky = 1'b1;
        m_eaddr  = ea;
      end
    end
    @(posedge clk);
    #1;
    chk("imem_we", 64'(imem_we), 64'(e_we));
    chk("err_pulse", 64'(err_pulse), 64'(e_ep));
    chk("count", 64'(count), 64'(m_count));
    chk("full", 64'(full), 64'(m_full));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("err_addr", 64'(err_addr), 64'(m_eaddr));
    chk("in_ready", 64'(in_ready), 64'(m_run && !m_full && !start));
    if (e_we) begin
      chk("imem_addr", 64'(imem_addr), 64'(ea));
      chk("imem_wdata", 64'(imem_wdata), 64'({op, rd_in, rs_in, rt_in, 10'b0}));
    end
  endtask

  task automatic drive(input logic [11:0] c, input logic v);
    ctl_in   = c;
    in_valid = v;
  endtask

  initial begin
    int snap;
    vt[0]  = '{12'b000_000000000, 4'h0, 1'b1};
    vt[1]  = '{12'b100_001100001, 4'hF, 1'b1};
    vt[2]  = '{12'b111_010100010, 4'hE, 1'b1};
    vt[3]  = '{12'b111_100000000, 4'h3, 1'b1};
    vt[4]  = '{12'b100_000100000, 4'h4, 1'b1};
    vt[5]  = '{12'b100_001100000, 4'h5, 1'b1};
    vt[6]  = '{12'b010_000100000, 4'h6, 1'b1};
    vt[7]  = '{12'b001_000100000, 4'h7, 1'b1};
    vt[8]  = '{12'b111_000000100, 4'h8, 1'b1};
    vt[9]  = '{12'b111_000010000, 4'h9, 1'b1};
    vt[10] = '{12'b111_000100001, 4'hA, 1'b1};
    vt[11] = '{12'b111_000001000, 4'hB, 1'b1};
    vt[12] = '{12'b111_000011000, 4'h0, 1'b0};
    vt[13] = '{12'b100_000000000, 4'h0, 1'b0};
    vt[14] = '{12'b011_000100000, 4'h0, 1'b0};

    m_run = 0; m_full = 0; m_sticky = 0; m_ptr = BASE; m_count = 0; m_eaddr = 0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; ctl_in = '0;
    rd_in = 6'd1; rs_in = 6'd2; rt_in = 6'd3;
    step();
    step();
    chk("rst_addr", 64'(imem_addr), 64'(BASE));
    chk("rst_wdata", 64'(imem_wdata), 64'(0));
    rst = 1'b0;

    // 1: one bundle per opcode, back to back
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].ctl, 1'b1);
      step();
      chk("t1_op", 64'(imem_wdata[31:28]), 64'(vt[i].op));
      chk("t1_addr", 64'(imem_addr), 64'(i));
    end
    drive('0, 1'b0); step();
    chk("t1_count", 64'(count), 64'(12));

    // 2: illegal bundle lands on address 5
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin drive(vt[i + 3].ctl, 1'b1); step(); end
    drive(vt[12].ctl, 1'b1); step();
    chk("t2_we", 64'(imem_we), 64'(0));
    chk("t2_pulse", 64'(err_pulse), 64'(1));
    chk("t2_eaddr", 64'(err_addr), 64'(5));
    drive(vt[4].ctl, 1'b1); step();
    chk("t2_pulse_off", 64'(err_pulse), 64'(0));
    chk("t2_addr", 64'(imem_addr), 64'(5));
    chk("t2_sticky", 64'(err_sticky), 64'(1));

    // 4: start beats a same-cycle valid bundle
    start = 1'b1; drive(vt[5].ctl, 1'b1); step(); start = 1'b0;
    step();
    chk("t4_we", 64'(imem_we), 64'(1));
    chk("t4_addr", 64'(imem_addr), 64'(BASE));
    chk("t4_sticky", 64'(err_sticky), 64'(0));
    drive('0, 1'b0); step();

    // 3: DEPTH=4 instance stops after four words
    start = 1'b1; step(); start = 1'b0;
    snap = w4_n;
    for (int i = 0; i < 5; i++) begin drive(vt[i + 1].ctl, 1'b1); step(); end
    drive('0, 1'b0); step(); step();
    chk("t3_writes", 64'(w4_n - snap), 64'(4));
    chk("t3_last_addr", 64'(w4_last), 64'(3));
    chk("t3_full", 64'(full4), 64'(1));
    chk("t3_ready", 64'(in_ready4), 64'(0));
    chk("t3_count", 64'(count4), 64'(4));

    // 6: valid toggling every other cycle
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rd_in = 6'($urandom); rs_in = 6'($urandom); rt_in = 6'($urandom);
      drive(vt[$urandom_range(0, 11)].ctl, (i % 2) == 0);
      step();
    end
    drive('0, 1'b0); step();
    chk("t6_count", 64'(count), 64'(10));

    // 5: reset right after an accept
    drive(vt[2].ctl, 1'b1); step();
    drive('0, 1'b0); rst = 1'b1; step();
    chk("t5_we", 64'(imem_we), 64'(0));
    chk("t5_addr", 64'(imem_addr), 64'(BASE));
    chk("t5_wdata", 64'(imem_wdata), 64'(0));
    chk("t5_count", 64'(count), 64'(0));
    chk("t5_ready", 64'(in_ready), 64'(0));
    rst = 1'b0;

    // randomized traffic with occasional start/rst
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 500; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 99) < 3);
      rd_in = 6'($urandom); rs_in = 6'($urandom); rt_in = 6'($urandom);
      if ($urandom_range(0, 3) != 0) drive(vt[$urandom_range(0, 11)].ctl, $urandom_range(0, 9) < 7);
      else drive(12'($urandom), $urandom_range(0, 9) < 7);
      step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
